// File: rtl/bp_mem_traffic_gen.sv
// Memory-command initiator: writes an address-derived pattern to a range of
// cache blocks, reads every block back and counts mismatching responses.
module bp_mem_traffic_gen #(
  parameter int                       paddr_width_p = 40,
  parameter int                       block_width_p = 512,
  parameter int                       num_blocks_p  = 16,
  parameter logic [paddr_width_p-1:0] base_addr_p   = paddr_width_p'(32'h8000_0000),
  parameter logic [63:0]              seed_p        = 64'h0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  output logic                     mem_cmd_w_o,
  output logic [paddr_width_p-1:0] mem_cmd_addr_o,
  output logic [block_width_p-1:0] mem_cmd_data_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,
  input  logic                     mem_resp_w_i,
  input  logic [paddr_width_p-1:0] mem_resp_addr_i,
  input  logic [block_width_p-1:0] mem_resp_data_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [7:0]               error_count_o,
  output logic [2:0]               debug_state_o
);

  localparam int block_bytes_lp = block_width_p / 8;
  localparam int words_lp       = block_width_p / 64;
  localparam int k_width_lp     = (num_blocks_p > 1) ? $clog2(num_blocks_p) : 1;
  localparam logic [k_width_lp-1:0] last_k_lp = k_width_lp'(num_blocks_p - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_WR = 3'd1,
    WAIT_WR = 3'd2,
    SEND_RD = 3'd3,
    WAIT_RD = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                   state_r, state_n;
  logic [k_width_lp-1:0]    k_r, k_n;
  logic [7:0]               err_r, err_n;
  logic                     mismatch;
  logic                     cmd_w_r;
  logic [paddr_width_p-1:0] cmd_addr_r;
  logic [block_width_p-1:0] cmd_data_r;

  function automatic logic [paddr_width_p-1:0] addr_of(input logic [k_width_lp-1:0] k);
    return base_addr_p + paddr_width_p'(k) * paddr_width_p'(block_bytes_lp);
  endfunction

  function automatic logic [block_width_p-1:0] pattern_of(input logic [paddr_width_p-1:0] a);
    logic [63:0] word;
    word = seed_p ^ 64'(a);
    return {words_lp{word}};
  endfunction

  // Handshakes: a command transfers on any cycle with mem_cmd_v_o & mem_cmd_ready_i,
  // and once raised, valid and the command fields hold until that transfer; a
  // response is consumed on any cycle with mem_resp_v_i & mem_resp_yumi_o.
  always_comb begin
    state_n         = state_r;
    k_n             = k_r;
    err_n           = err_r;
    mismatch        = 1'b0;
    mem_resp_yumi_o = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_n = SEND_WR;
          k_n     = '0;
          err_n   = '0;
        end
      end
      SEND_WR: if (mem_cmd_ready_i) state_n = WAIT_WR;
      WAIT_WR: begin
        if (mem_resp_v_i) begin
          mem_resp_yumi_o = 1'b1;
          mismatch = !mem_resp_w_i || (mem_resp_addr_i != cmd_addr_r);
          if (k_r == last_k_lp) begin
            k_n     = '0;
            state_n = SEND_RD;
          end else begin
            k_n     = k_r + k_width_lp'(1);
            state_n = SEND_WR;
          end
        end
      end
      SEND_RD: if (mem_cmd_ready_i) state_n = WAIT_RD;
      WAIT_RD: begin
        if (mem_resp_v_i) begin
          mem_resp_yumi_o = 1'b1;
          mismatch = mem_resp_w_i || (mem_resp_addr_i != cmd_addr_r)
                     || (mem_resp_data_i != pattern_of(cmd_addr_r));
          if (k_r == last_k_lp) begin
            state_n = DONE;
          end else begin
            k_n     = k_r + k_width_lp'(1);
            state_n = SEND_RD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (mismatch && (err_r != 8'hFF)) err_n = err_r + 8'd1;
  end

  // Command fields are loaded from the next-state view so they are already
  // registered in the first SEND cycle and stay frozen through WAIT.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      k_r        <= '0;
      err_r      <= '0;
      cmd_w_r    <= 1'b0;
      cmd_addr_r <= '0;
      cmd_data_r <= '0;
    end else begin
      state_r <= state_n;
      k_r     <= k_n;
      err_r   <= err_n;
      case (state_n)
        SEND_WR: begin
          cmd_w_r    <= 1'b1;
          cmd_addr_r <= addr_of(k_n);
          cmd_data_r <= pattern_of(addr_of(k_n));
        end
        SEND_RD: begin
          cmd_w_r    <= 1'b0;
          cmd_addr_r <= addr_of(k_n);
          cmd_data_r <= '0;
        end
        WAIT_WR, WAIT_RD: begin
        end
        default: begin
          cmd_w_r    <= 1'b0;
          cmd_addr_r <= '0;
          cmd_data_r <= '0;
        end
      endcase
    end
  end

  assign mem_cmd_v_o    = (state_r == SEND_WR) || (state_r == SEND_RD);
  assign mem_cmd_w_o    = cmd_w_r;
  assign mem_cmd_addr_o = cmd_addr_r;
  assign mem_cmd_data_o = cmd_data_r;
  assign busy_o         = mem_cmd_v_o || (state_r == WAIT_WR) || (state_r == WAIT_RD);
  assign done_o         = (state_r == DONE);
  assign error_count_o  = err_r;
  assign debug_state_o  = state_r;

endmodule

// File: tb/tb_bp_mem_traffic_gen.sv
// Directed bench for bp_mem_traffic_gen: a 4-block instance for most scenarios
// and a 300-block instance for error-count saturation, sharing one responder.
module tb_bp_mem_traffic_gen;

  localparam logic [39:0] BASE = 40'h00_8000_0000;

  logic         clk, reset, start_a, start_b, sel_b;
  logic         ready, resp_w, resp_v;
  logic [39:0]  resp_addr;
  logic [511:0] resp_data;

  logic         cmd_w_a, cmd_v_a, yumi_a, busy_a, done_a;
  logic [39:0]  cmd_addr_a;
  logic [511:0] cmd_data_a;
  logic [7:0]   err_a;
  logic [2:0]   state_a;
  logic         cmd_w_b, cmd_v_b, yumi_b, busy_b, done_b;
  logic [39:0]  cmd_addr_b;
  logic [511:0] cmd_data_b;
  logic [7:0]   err_b;
  logic [2:0]   state_b;

  logic         cmd_w, cmd_v, yumi, busy, done;
  logic [39:0]  cmd_addr;
  logic [511:0] cmd_data;
  logic [7:0]   err_cnt;

  assign cmd_w    = sel_b ? cmd_w_b    : cmd_w_a;
  assign cmd_v    = sel_b ? cmd_v_b    : cmd_v_a;
  assign yumi     = sel_b ? yumi_b     : yumi_a;
  assign busy     = sel_b ? busy_b     : busy_a;
  assign done     = sel_b ? done_b     : done_a;
  assign cmd_addr = sel_b ? cmd_addr_b : cmd_addr_a;
  assign cmd_data = sel_b ? cmd_data_b : cmd_data_a;
  assign err_cnt  = sel_b ? err_b      : err_a;

  bp_mem_traffic_gen #(.num_blocks_p(4)) dut_a (
    .clk_i(clk), .reset_i(reset), .start_i(start_a),
    .mem_cmd_w_o(cmd_w_a), .mem_cmd_addr_o(cmd_addr_a), .mem_cmd_data_o(cmd_data_a),
    .mem_cmd_v_o(cmd_v_a), .mem_cmd_ready_i(ready),
    .mem_resp_w_i(resp_w), .mem_resp_addr_i(resp_addr), .mem_resp_data_i(resp_data),
    .mem_resp_v_i(resp_v), .mem_resp_yumi_o(yumi_a),
    .busy_o(busy_a), .done_o(done_a), .error_count_o(err_a), .debug_state_o(state_a)
  );

  bp_mem_traffic_gen #(.num_blocks_p(300)) dut_b (
    .clk_i(clk), .reset_i(reset), .start_i(start_b),
    .mem_cmd_w_o(cmd_w_b), .mem_cmd_addr_o(cmd_addr_b), .mem_cmd_data_o(cmd_data_b),
    .mem_cmd_v_o(cmd_v_b), .mem_cmd_ready_i(ready),
    .mem_resp_w_i(resp_w), .mem_resp_addr_i(resp_addr), .mem_resp_data_i(resp_data),
    .mem_resp_v_i(resp_v), .mem_resp_yumi_o(yumi_b),
    .busy_o(busy_b), .done_o(done_b), .error_count_o(err_b), .debug_state_o(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // responder state, options and run results
  bit           pend;
  logic         pend_w;
  logic [39:0]  pend_addr;
  logic [511:0] pend_data;
  logic [511:0] mem [logic [39:0]];
  logic         log_w[$];
  logic [39:0]  log_addr[$];
  logic [511:0] log_data[$];
  int opt_stall, opt_flip_blk, opt_badaddr_blk, opt_start_step, opt_stop_step;
  bit opt_same, opt_zero_rd;
  int run_cycles, hs_yumi, consumed, stall_v, stall_chg;

  function automatic logic [511:0] exp_pat(input logic [39:0] a);
    return {8{64'(a)}};
  endfunction

  task automatic clear_opts();
    opt_stall = 0; opt_flip_blk = -1; opt_badaddr_blk = -1;
    opt_start_step = -1; opt_stop_step = -1; opt_same = 0; opt_zero_rd = 0;
    hs_yumi = 0; consumed = 0; stall_v = 0; stall_chg = 0; run_cycles = -1;
    pend = 0;
    log_w.delete(); log_addr.delete(); log_data.delete();
  endtask

  task automatic start_run(input bit b);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Cycle-by-cycle responder, called and returning on a falling edge.
  task automatic run(input int budget);
    logic [39:0]  st_addr;
    logic [511:0] st_data;
    int rd_idx;
    rd_idx = 0;
    st_addr = '0; st_data = '0;
    run_cycles = -1;
    for (int n = 0; n < budget; n++) begin
      if (done) begin run_cycles = n; break; end
      if (n == opt_stop_step) break;
      start_a = (n == opt_start_step);
      resp_v = pend; resp_w = pend_w; resp_addr = pend_addr; resp_data = pend_data;
      ready = (n >= opt_stall);
      #1;
      if (n < opt_stall) begin
        if (cmd_v) stall_v++;
        if (n == 0) begin st_addr = cmd_addr; st_data = cmd_data; end
        else if (cmd_addr !== st_addr || cmd_data !== st_data) stall_chg++;
      end
      if (resp_v && yumi) begin consumed++; pend = 0; end
      if (cmd_v && ready) begin
        log_w.push_back(cmd_w); log_addr.push_back(cmd_addr); log_data.push_back(cmd_data);
        pend = 1; pend_w = cmd_w; pend_addr = cmd_addr;
        if (cmd_w) begin
          mem[cmd_addr] = cmd_data;
          pend_data = '0;
        end else begin
          pend_data = (!opt_zero_rd && mem.exists(cmd_addr)) ? mem[cmd_addr] : '0;
          if (rd_idx == opt_flip_blk) pend_data[0] = ~pend_data[0];
          if (rd_idx == opt_badaddr_blk) pend_addr = pend_addr ^ 40'h1000;
          rd_idx++;
        end
        if (opt_same) begin
          resp_v = 1'b1; resp_w = pend_w; resp_addr = pend_addr; resp_data = pend_data;
          #1;
          if (yumi) hs_yumi++;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    start_a = 1'b0;
    resp_v = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (cmd_v !== 1'b0) begin errors++; $display("FAIL reset_cmd_v: got %0h expected 0", cmd_v); end
    checks++; if (yumi !== 1'b0) begin errors++; $display("FAIL reset_yumi: got %0h expected 0", yumi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0h/%0h expected 0/0", busy, done); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
    checks++; if (cmd_w !== 1'b0 || cmd_addr !== 40'd0 || cmd_data !== 512'd0) begin errors++; $display("FAIL reset_fields: got w=%0h addr=%0h expected zeros", cmd_w, cmd_addr); end
    checks++; if (state_a !== 3'd0 || state_b !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d/%0d expected 0/0", state_a, state_b); end
  endtask

  task automatic test_ideal();
    logic [39:0]  ea;
    logic [511:0] ed;
    logic [511:0] blk1;
    blk1 = {8{64'h0000_0000_8000_0040}};
    clear_opts();
    start_run(0);
    checks++; if (cmd_v !== 1'b1 || cmd_w !== 1'b1 || cmd_addr !== BASE) begin errors++; $display("FAIL start_latency: got v=%0h w=%0h addr=%0h expected 1 1 %0h", cmd_v, cmd_w, cmd_addr, BASE); end
    run(100);
    checks++; if (run_cycles !== 16) begin errors++; $display("FAIL ideal_cycles: got %0d expected 16", run_cycles); end
    checks++; if (log_w.size() !== 8) begin errors++; $display("FAIL ideal_count: got %0d expected 8", log_w.size()); end
    for (int i = 0; i < 8 && i < log_w.size(); i++) begin
      ea = BASE + 40'(64 * (i % 4));
      ed = (i < 4) ? exp_pat(ea) : 512'd0;
      checks++;
      if (log_w[i] !== (i < 4) || log_addr[i] !== ea || log_data[i] !== ed) begin
        errors++;
        $display("FAIL ideal_cmd%0d: got w=%0h addr=%0h expected w=%0h addr=%0h", i, log_w[i], log_addr[i], (i < 4), ea);
      end
    end
    if (log_data.size() > 1) begin
      checks++; if (log_data[1] !== blk1) begin errors++; $display("FAIL ideal_blk1_data: got %h expected %h", log_data[1][63:0], blk1[63:0]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ideal_done: got done=%0h busy=%0h expected 1 0", done, busy); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ideal_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_stall();
    int wr0;
    clear_opts();
    opt_stall = 5;
    start_run(0);
    run(100);
    wr0 = 0;
    foreach (log_w[i]) if (log_w[i] === 1'b1 && log_addr[i] === BASE) wr0++;
    checks++; if (stall_v !== 5) begin errors++; $display("FAIL stall_valid_held: got %0d expected 5", stall_v); end
    checks++; if (stall_chg !== 0) begin errors++; $display("FAIL stall_fields_stable: got %0d changes expected 0", stall_chg); end
    checks++; if (wr0 !== 1) begin errors++; $display("FAIL stall_single_write: got %0d expected 1", wr0); end
    checks++; if (log_w.size() !== 8 || done !== 1'b1 || err_cnt !== 8'd0) begin errors++; $display("FAIL stall_run: got n=%0d done=%0h err=%0d expected 8 1 0", log_w.size(), done, err_cnt); end
  endtask

  task automatic test_same_cycle();
    clear_opts();
    opt_same = 1;
    start_run(0);
    run(100);
    checks++; if (hs_yumi !== 0) begin errors++; $display("FAIL same_cycle_yumi: got %0d expected 0", hs_yumi); end
    checks++; if (consumed !== 8) begin errors++; $display("FAIL same_cycle_consumed: got %0d expected 8", consumed); end
    checks++; if (run_cycles !== 16 || log_w.size() !== 8) begin errors++; $display("FAIL same_cycle_run: got cyc=%0d n=%0d expected 16 8", run_cycles, log_w.size()); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL same_cycle_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_start_ignored();
    clear_opts();
    opt_start_step = 1;
    start_run(0);
    run(100);
    checks++; if (run_cycles !== 16 || log_w.size() !== 8) begin errors++; $display("FAIL start_in_wait: got cyc=%0d n=%0d expected 16 8", run_cycles, log_w.size()); end
    checks++; if (err_cnt !== 8'd0 || done !== 1'b1) begin errors++; $display("FAIL start_in_wait_done: got err=%0d done=%0h expected 0 1", err_cnt, done); end
  endtask

  task automatic test_errors();
    clear_opts();
    opt_flip_blk = 2;
    opt_badaddr_blk = 3;
    start_run(0);
    run(100);
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL error_count: got %0d expected 2", err_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL error_done: got %0h expected 1", done); end
  endtask

  task automatic test_restart_from_done();
    clear_opts();
    start_run(0);
    checks++; if (err_cnt !== 8'd0 || done !== 1'b0) begin errors++; $display("FAIL restart_clear: got err=%0d done=%0h expected 0 0", err_cnt, done); end
    checks++; if (cmd_v !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL restart_cmd_v: got v=%0h busy=%0h expected 1 1", cmd_v, busy); end
    run(100);
    checks++; if (run_cycles !== 16 || err_cnt !== 8'd0) begin errors++; $display("FAIL restart_run: got cyc=%0d err=%0d expected 16 0", run_cycles, err_cnt); end
  endtask

  task automatic test_reset_mid_run();
    clear_opts();
    opt_stop_step = 10;
    start_run(0);
    run(100);
    #1;
    checks++; if (cmd_v !== 1'b1 || cmd_w !== 1'b0 || cmd_addr !== BASE + 40'h40) begin errors++; $display("FAIL mid_run_position: got v=%0h w=%0h addr=%0h expected 1 0 %0h", cmd_v, cmd_w, cmd_addr, BASE + 40'h40); end
    reset = 1'b1;
    resp_v = 1'b1; resp_w = 1'b0; resp_addr = BASE; resp_data = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (cmd_v !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || yumi !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got v=%0h busy=%0h done=%0h yumi=%0h expected 0", cmd_v, busy, done, yumi); end
    checks++; if (cmd_w !== 1'b0 || cmd_addr !== 40'd0 || cmd_data !== 512'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_fields: got addr=%0h err=%0d expected 0 0", cmd_addr, err_cnt); end
    @(posedge clk); @(negedge clk);
    checks++; if (yumi !== 1'b0) begin errors++; $display("FAIL idle_not_consumed: got %0h expected 0", yumi); end
    resp_v = 1'b0;
    clear_opts();
    start_run(0);
    run(100);
    checks++; if (run_cycles !== 16 || log_w.size() !== 8 || err_cnt !== 8'd0) begin errors++; $display("FAIL post_reset_run: got cyc=%0d n=%0d err=%0d expected 16 8 0", run_cycles, log_w.size(), err_cnt); end
  endtask

  task automatic test_saturate();
    sel_b = 1'b1;
    clear_opts();
    opt_zero_rd = 1;
    start_run(1);
    run(1400);
    checks++; if (run_cycles !== 1200 || log_w.size() !== 600) begin errors++; $display("FAIL sat_run: got cyc=%0d n=%0d expected 1200 600", run_cycles, log_w.size()); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", err_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done: got %0h expected 1", done); end
    sel_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel_b = 1'b0;
    ready = 1'b0; resp_v = 1'b0; resp_w = 1'b0; resp_addr = '0; resp_data = '0;
    pend = 0; pend_w = 1'b0; pend_addr = '0; pend_data = '0;
    clear_opts();
    test_reset();
    test_ideal();
    test_stall();
    test_same_cycle();
    test_start_ignored();
    test_errors();
    test_restart_from_done();
    test_reset_mid_run();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
